spectrum_bar_renderer: RTL and testbench

//  Pixel-data source for lcd_driver. Takes the pixel_x/pixel_y it requests and returns pixel_data,

---
 rtl/spectrum_bar_renderer.sv | 155 +++++++++++++++
 tb/tb_spectrum_bar_renderer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_bar_renderer.sv
// FFT bar-graph pixel source for lcd_driver: double-buffered bar heights, peak-hold markers,
// 1-cycle pixel latency, bank swap only at frame end.
module spectrum_bar_renderer #(
  parameter int          NUM_BARS     = 32,
  parameter int          BAR_W        = 15,
  parameter int          H_DISP       = 480,
  parameter int          V_DISP       = 272,
  parameter int          MAG_SHIFT    = 6,
  parameter int          DECAY_FRAMES = 4,
  parameter logic [15:0] BAR_COLOR    = 16'h07E0,
  parameter logic [15:0] PEAK_COLOR   = 16'hF800,
  parameter logic [15:0] BG_COLOR     = 16'h0000
) (
  input  logic        lcd_pclk,
  input  logic        sys_rst,
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  input  logic        bin_valid,
  input  logic [15:0] bin_mag,
  input  logic        bin_last,
  output logic        bin_ready,
  output logic [15:0] pixel_data,
  output logic        frame_swap
);
  localparam int BW = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
  localparam int CW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int DW = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

  typedef enum logic [1:0] {S_FILL, S_FULL, S_SWAP} state_e;

  state_e                          state_q, state_d;
  logic                            disp_sel_q, disp_sel_d;
  logic [1:0][NUM_BARS-1:0][8:0]   bank_q, bank_d;
  logic [NUM_BARS-1:0][8:0]        pk_q, pk_d;
  logic [BW-1:0]                   wr_idx_q, wr_idx_d;
  logic [DW-1:0]                   dec_q, dec_d;
  logic [10:0]                     prev_y_q, prev_y_d;
  logic [CW-1:0]                   col_q, col_d;
  logic [BW-1:0]                   bar_q, bar_d;
  logic                            bin_ready_q, bin_ready_d;
  logic                            frame_swap_q, frame_swap_d;
  logic [15:0]                     pix_q, pix_d;

  logic        frame_end, accept, swap, decay_wrap;
  logic [15:0] mag_sh;
  logic [8:0]  sat_h, h, p;
  logic [10:0] bar_top, pk_row;

  assign frame_end  = (prev_y_q == 11'(V_DISP)) && (pixel_y == 11'd0);
  assign accept     = bin_valid && bin_ready_q && (state_q == S_FILL);
  assign swap       = (state_q == S_FULL) && frame_end;
  assign decay_wrap = frame_end && (dec_q == DW'(DECAY_FRAMES - 1));
  assign mag_sh     = bin_mag >> MAG_SHIFT;
  assign sat_h      = (mag_sh > 16'(V_DISP)) ? 9'(V_DISP) : mag_sh[8:0];

  assign h       = bank_q[disp_sel_q][bar_q];
  assign p       = pk_q[bar_q];
  assign bar_top = 11'(V_DISP) - {2'b00, h};
  assign pk_row  = 11'(V_DISP + 1) - {2'b00, p};

  always_comb begin
    logic [8:0] dec_v;
    logic [8:0] nh_v;
    state_d      = state_q;
    disp_sel_d   = disp_sel_q;
    bank_d       = bank_q;
    pk_d         = pk_q;
    wr_idx_d     = wr_idx_q;
    dec_d        = dec_q;
    prev_y_d     = pixel_y;
    col_d        = col_q;
    bar_d        = bar_q;
    dec_v        = '0;
    nh_v         = '0;

    // Column/bar trackers assume pixel_x steps by one from 1 after each blanking cycle.
    if (pixel_x == 11'd0) begin
      col_d = '0;
      bar_d = '0;
    end else if (col_q == CW'(BAR_W - 1)) begin
      col_d = '0;
      bar_d = bar_q + BW'(1);
    end else begin
      col_d = col_q + CW'(1);
    end

    if (pixel_x == 11'd0 || pixel_y == 11'd0)      pix_d = 16'h0000;
    else if (col_q == CW'(BAR_W - 1))               pix_d = BG_COLOR;
    else if (pixel_y > bar_top)                     pix_d = BAR_COLOR;
    else if (p > h && pixel_y == pk_row)            pix_d = PEAK_COLOR;
    else                                            pix_d = BG_COLOR;

    case (state_q)
      S_FILL: if (accept) begin
        bank_d[~disp_sel_q][wr_idx_q] = sat_h;
        wr_idx_d = wr_idx_q + BW'(1);
        if (bin_last || wr_idx_q == BW'(NUM_BARS - 1)) state_d = S_FULL;
      end
      S_FULL: if (frame_end) begin
        state_d            = S_SWAP;
        disp_sel_d         = ~disp_sel_q;
        bank_d[disp_sel_q] = '0;
        wr_idx_d           = '0;
      end
      default: state_d = S_FILL;
    endcase

    // New peaks see the incoming display bank, i.e. the current write bank.
    if (frame_end) begin
      dec_d = decay_wrap ? '0 : dec_q + DW'(1);
      for (int i = 0; i < NUM_BARS; i++) begin
        dec_v = (decay_wrap && pk_q[i] != 9'd0) ? pk_q[i] - 9'd1 : pk_q[i];
        nh_v  = bank_q[~disp_sel_q][i];
        pk_d[i] = (swap && nh_v > dec_v) ? nh_v : dec_v;
      end
    end

    frame_swap_d = swap;
    bin_ready_d  = (state_d == S_FILL);
  end

  always_ff @(posedge lcd_pclk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q      <= S_FILL;
      disp_sel_q   <= 1'b0;
      bank_q       <= '0;
      pk_q         <= '0;
      wr_idx_q     <= '0;
      dec_q        <= '0;
      prev_y_q     <= '0;
      col_q        <= '0;
      bar_q        <= '0;
      bin_ready_q  <= 1'b0;
      frame_swap_q <= 1'b0;
      pix_q        <= '0;
    end else begin
      state_q      <= state_d;
      disp_sel_q   <= disp_sel_d;
      bank_q       <= bank_d;
      pk_q         <= pk_d;
      wr_idx_q     <= wr_idx_d;
      dec_q        <= dec_d;
      prev_y_q     <= prev_y_d;
      col_q        <= col_d;
      bar_q        <= bar_d;
      bin_ready_q  <= bin_ready_d;
      frame_swap_q <= frame_swap_d;
      pix_q        <= pix_d;
    end
  end

  assign bin_ready  = bin_ready_q;
  assign frame_swap = frame_swap_q;
  assign pixel_data = pix_q;
endmodule

// File: tb/tb_spectrum_bar_renderer.sv
// Bench for spectrum_bar_renderer: behavioural model feeds a scoreboard queue each cycle,
// plus constant expectation tables and hand-written corner sequences.
module tb_spectrum_bar_renderer;
  localparam logic [15:0] BAR  = 16'h07E0;
  localparam logic [15:0] PEAK = 16'hF800;
  localparam logic [15:0] BG   = 16'h0000;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [10:0] px, py;
  logic        bv, bl;
  logic [15:0] bm;
  logic        br, fs;
  logic [15:0] pd;

  always #5 clk = ~clk;

  spectrum_bar_renderer dut (
    .lcd_pclk(clk), .sys_rst(sys_rst), .pixel_x(px), .pixel_y(py),
    .bin_valid(bv), .bin_mag(bm), .bin_last(bl),
    .bin_ready(br), .pixel_data(pd), .frame_swap(fs)
  );

  typedef struct { logic [15:0] pix; logic rdy; logic swp; } exp_t;
  typedef struct { int x; int y; logic [15:0] exp; } vec_t;

  exp_t sbq[$];
  int   n_chk = 0, n_pass = 0;

  int m_bank[2][32];
  int m_pk[32];
  int m_sel, m_dec, m_st, m_widx, m_prev_y;
  bit m_rdy;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic int exp_pix(input int x, input int y);
    int b, c, h, p;
    if (x == 0 || y == 0) return 0;
    b = (x - 1) / 15;
    c = (x - 1) % 15;
    h = m_bank[m_sel][b];
    p = m_pk[b];
    if (c == 14) return BG;
    if (y > 272 - h) return BAR;
    if (p > h && y == 273 - p) return PEAK;
    return BG;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_bank[0][i] = 0; m_bank[1][i] = 0; m_pk[i] = 0;
    end
    m_sel = 0; m_dec = 0; m_st = 0; m_widx = 0; m_rdy = 0; m_prev_y = 0;
    sbq.delete();
  endtask

  // One clock: drive inputs, advance the model, compare the registered outputs.
  task automatic cycle(input int x, input int y, input bit v = 0, input int mag = 0, input bit last = 0);
    exp_t e;
    bit fe, sw, acc;
    int d, nh, hh;
    px = 11'(x); py = 11'(y); bv = v; bm = 16'(mag); bl = last;
    e.pix = 16'(exp_pix(x, y));
    fe  = (m_prev_y == 272 && y == 0);
    sw  = (m_st == 1 && fe);
    acc = v && m_rdy;
    if (fe) begin
      for (int i = 0; i < 32; i++) begin
        d = m_pk[i];
        if (m_dec == 3 && d > 0) d--;
        nh = m_bank[1 - m_sel][i];
        m_pk[i] = (sw && nh > d) ? nh : d;
      end
      m_dec = (m_dec + 1) % 4;
    end
    if (m_st == 0 && acc) begin
      hh = mag >> 6;
      if (hh > 272) hh = 272;
      m_bank[1 - m_sel][m_widx] = hh;
      if (last || m_widx == 31) m_st = 1;
      m_widx++;
    end else if (sw) begin
      for (int i = 0; i < 32; i++) m_bank[m_sel][i] = 0;
      m_sel = 1 - m_sel; m_widx = 0; m_st = 2;
    end else if (m_st == 2) begin
      m_st = 0;
    end
    m_rdy = (m_st == 0);
    e.rdy = m_rdy; e.swp = sw;
    m_prev_y = y;
    sbq.push_back(e);
    @(posedge clk); #1;
    e = sbq.pop_front();
    chk("pixel_data", pd, e.pix);
    chk("bin_ready", br, e.rdy);
    chk("frame_swap", fs, e.swp);
  endtask

  task automatic frame_end();
    cycle(0, 272);
    cycle(0, 0);
  endtask

  task automatic scan_row(input int y, input int n);
    for (int x = 0; x <= n; x++) cycle(x, y);
    cycle(0, (y == 272) ? 1 : 0);
  endtask

  task automatic pix_at(input int x, input int y, input logic [15:0] exp, input string nm);
    for (int i = 0; i <= x; i++) cycle(i, y);
    chk(nm, pd, exp);
    cycle(0, (y == 272) ? 1 : 0);
  endtask

  task automatic send_bin(input int mag, input bit last);
    int t = 0;
    while (!m_rdy && t < 20) begin cycle(0, 0); t++; end
    if (!m_rdy) chk("ready_timeout", br, 1);
    else cycle(0, 0, 1, mag, last);
  endtask

  task automatic async_reset(input string tag);
    #3 sys_rst = 1'b0;
    #1;
    chk({tag, "_pix"}, pd, 0);
    chk({tag, "_rdy"}, br, 0);
    chk({tag, "_swap"}, fs, 0);
    px = '0; py = '0; bv = 0; bm = '0; bl = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 sys_rst = 1'b1;
    chk({tag, "_rdy_release"}, br, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    tbl[0] = '{76, 193, BAR};  tbl[1] = '{76, 192, BG};   tbl[2] = '{89, 193, BAR};
    tbl[3] = '{90, 272, BG};   tbl[4] = '{1, 272, BG};    tbl[5] = '{16, 272, BAR};
    tbl[6] = '{16, 257, BAR};  tbl[7] = '{16, 256, BG};   tbl[8] = '{480, 100, BG};
    tbl[9] = '{466, 1, BAR};

    sys_rst = 1'b0; px = '0; py = '0; bv = 0; bm = '0; bl = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #3;
    chk("reset_pix", pd, 0);
    chk("reset_rdy", br, 0);
    chk("reset_swap", fs, 0);
    sys_rst = 1'b1;
    chk("rdy_at_release", br, 0);

    // Blank display after reset
    scan_row(1, 480); scan_row(136, 480); scan_row(272, 480);
    frame_end();

    // Full spectrum k*1024
    for (int k = 0; k < 32; k++) send_bin(k * 1024, k == 31);
    chk("rdy_after_32", br, 0);
    cycle(0, 0); cycle(0, 5);
    chk("no_swap_before_fe", fs, 0);
    frame_end();
    chk("swap_pulse", fs, 1);
    for (int i = 0; i < 10; i++) pix_at(tbl[i].x, tbl[i].y, tbl[i].exp, "full_spectrum_vec");
    scan_row(193, 480);

    // Saturation with early last on first bin
    send_bin(16'hFFFF, 1);
    frame_end();
    pix_at(1, 1, BAR, "sat_1_1");
    scan_row(200, 480);

    // Early last on third bin
    for (int k = 0; k < 3; k++) send_bin(16'h1000, k == 2);
    chk("rdy_after_early_last", br, 0);
    frame_end();
    pix_at(31, 272, BAR, "bar2_h64");
    pix_at(46, 272, BG, "bar3_empty");
    scan_row(272, 480);

    // Accept on the frame-end cycle while filling
    send_bin(16'h2000, 0);
    cycle(0, 272);
    cycle(0, 0, 1, 16'h3000, 0);
    chk("fe_accept_no_swap", fs, 0);
    send_bin(16'h4000, 1);
    cycle(0, 0);
    chk("full_no_swap_yet", fs, 0);
    frame_end();
    chk("swap_after_complete", fs, 1);
    pix_at(16, 81, BAR, "bar1_h192");
    pix_at(16, 80, BG, "bar1_above");

    // Reset mid-fill and mid-row
    send_bin(16'h8000, 0);
    cycle(0, 100); cycle(1, 100); cycle(2, 100);
    async_reset("midrst");
    scan_row(1, 480); scan_row(272, 480);

    // Peak decay
    send_bin(6400, 1);
    frame_end();
    pix_at(1, 173, BAR, "decay_h100");
    send_bin(0, 1); frame_end();
    pix_at(1, 173, PEAK, "peak_173");
    pix_at(1, 172, BG, "peak_172_bg");
    pix_at(1, 174, BG, "peak_174_bg");
    send_bin(0, 1); frame_end();
    send_bin(0, 1); frame_end();
    pix_at(1, 174, PEAK, "peak_174");
    pix_at(1, 173, BG, "peak_173_gone");
    for (int f = 0; f < 400; f++) begin
      send_bin(0, 1);
      frame_end();
    end
    pix_at(1, 272, BG, "peak_gone");
    scan_row(272, 480);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
